clusterop_mac_pipe: RTL and testbench
=====================================

Name: clusterop_mac_pipe

Overview:
Parametrised, fully pipelined signed-by-(un)signed multiply-accumulate unit for the clusterOp datapath. It generalises the fixed 13s×9ns 4-stage multiplier in three ways: configurable operand, product and accumulator widths; a configurable pipeline depth; and a valid/ready handshake with whole-pipe stall. It adds a grouped accumulator that sums the products of one group (marked by first/last flags) and presents the group sum on the last beat. It sits between the distance/feature fetch stage and the cluster update logic.

Parameters:
A_W, 13, width of din0 (always signed)
B_W, 9, width of din1
B_SIGNED, 0, 1 = din1 is signed; 0 = din1 is unsigned (zero-extended by one bit before the multiply)
P_W, 13, dout width; low P_W bits of the full product, sign-extended if P_W > A_W+B_W
ACC_W, 24, accumulator width, two's complement
NUM_STAGE, 4, input-to-output latency in cycles; legal range 2..8

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  unit can accept a beat
din0  in  A_W  signed operand a
din1  in  B_W  operand b
in_first  in  1  beat starts an accumulation group
in_last  in  1  beat ends a group (in_first and in_last may both be 1)
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the beat
dout  out  P_W  product of this beat, truncated
acc_valid  out  1  equals out_valid and the last flag of the output beat
acc_out  out  ACC_W  group sum including the current beat
acc_ovf  out  1  sticky overflow for the current group (feature-dependent)

Behaviour:
- Reset (reset=0, asynchronous): all stage valid bits, acc_reg and ovf flag are cleared. out_valid=0, acc_valid=0, acc_ovf=0, dout=0, acc_out=0. Any in-flight beats are discarded.
- Stall: stall = out_valid & ~out_ready; in_ready = ~stall. A beat is accepted when in_valid & in_ready. While stall=1, every stage, including its valid bit and sideband, holds. When stall=0, every stage advances, and bubbles travel as valid=0 entries.
- Pipeline:
  - Stage 0 registers a, b, first and last.
  - Stage 1 computes the full product, width A_W+B_W+(B_SIGNED?0:1), as a signed multiply.
  - Stages 2..NUM_STAGE-1 are delay registers.
  - The last stage drives out_valid and dout.
  - Absent stalls, latency is NUM_STAGE cycles and throughput is 1 beat per cycle.
- Accumulation (combinational on the output beat):
  - sum = (first ? 0 : acc_reg) + sign-extended product, computed in ACC_W bits.
  - acc_out = sum.
  - On the output handshake (out_valid & out_ready), acc_reg <= sum.
  - When last is also set, acc_reg <= 0 and the ovf flag is cleared after the handshake.
- A beat with first=0 arriving with no group open accumulates onto acc_reg, which is 0 after reset or after a last beat. This is not an error.
- acc_out and acc_valid are only meaningful while out_valid=1. acc_out holds its value during a stall.
- Without the optional feature, the accumulator wraps modulo 2^ACC_W and acc_ovf is tied to 0.

Optional Feature:
CLUSTEROP_MAC_SAT_EN
- Defined:
  - sum saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Overflow is detected on the ACC_W+1-bit sum.
  - acc_ovf = ovf_flag | (overflow on the current beat). The flag is sticky until the group's last beat is accepted, or until reset.
- Undefined:
  - Two's-complement wrap.
  - acc_ovf is constant 0; the port remains present.

Decomposition:
- Package clusterop_mac_pkg:
  - Localparam function for the full product width.
  - Saturation-bound helper functions sat_max(w) and sat_min(w).
  - Struct typedef for the stage payload {product, first, last}.
- One sub-module: clusterop_mac_stage, a single stall-able pipeline register carrying {valid, payload}, instantiated NUM_STAGE times via generate.
- Accumulator and saturation logic live in the top module.

Test Plan:
- Defaults, out_ready=1. Single beat din0=-5, din1=200, first=last=1 -> 4 cycles later: out_valid=1, dout=13'h1C18 (-1000), acc_valid=1, acc_out=-1000.
- Group of 3 back-to-back beats: (100,3,first), (-7,10), (2,255,last) -> three consecutive out beats with dout=300, -70, 510. acc_out on the last beat is 740, with acc_valid=1 only on the third beat.
- Backpressure: stream 6 beats while out_ready=0 for cycles 5-7 -> in_ready=0 during the stall, no beat lost or duplicated, output order is preserved, and acc_out holds during the stall.
- Saturation: 5 beats of (-4096,511) in one group.
  - With CLUSTEROP_MAC_SAT_EN: final acc_out=24'h800000 and acc_ovf=1.
  - Without it: acc_out=6311936 and acc_ovf=0.
  - The next group's acc_ovf starts at 0.
- Reset mid-stream: assert reset low for 1 cycle with 3 beats in flight -> out_valid drops immediately (asynchronously) and no stale beat emerges. A subsequent single beat (3,4,first,last) gives acc_out=12.
- Parameter sweep NUM_STAGE=2 and 8, B_SIGNED=1, din1=-1 (9'h1FF), din0=7 -> latency 2 and 8 respectively, dout=-7.

Source files
------------

// File: rtl/clusterop_mac_pkg.sv
// ============================================================================
// Module      : clusterop_mac_pkg
// Description : Shared types and width/saturation helpers for the MAC pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clusterop_mac_pkg;

  // Group sideband that travels with every beat through the pipe.
  typedef struct packed {
    logic first;
    logic last;
  } mac_flags_t;

  // An unsigned b operand gains one zero bit so the multiply can stay signed.
  function automatic int full_prod_w(input int a_w, input int b_w, input int b_signed);
    return a_w + b_w + ((b_signed != 0) ? 0 : 1);
  endfunction

  function automatic longint sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/clusterop_mac_stage.sv
// ============================================================================
// Module      : clusterop_mac_stage
// Description : One stall-able pipeline register holding {valid, data, flags}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clusterop_mac_stage
  import clusterop_mac_pkg::*;
#(
  parameter int DATA_W = 23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  mac_flags_t        in_flags,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output mac_flags_t        out_flags
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  mac_flags_t        r_flags;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_flags <= '0;
    end else if (!stall) begin
      r_valid <= in_valid;
      r_data  <= in_data;
      r_flags <= in_flags;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_flags = r_flags;

endmodule

`default_nettype wire

// File: rtl/clusterop_mac_pipe.sv
// ============================================================================
// Module      : clusterop_mac_pipe
// Description : Pipelined signed x (un)signed multiply with grouped accumulate;
//               define CLUSTEROP_MAC_SAT_EN for a saturating accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clusterop_mac_pipe
  import clusterop_mac_pkg::*;
#(
  parameter int A_W       = 13,
  parameter int B_W       = 9,
  parameter int B_SIGNED  = 0,
  parameter int P_W       = 13,
  parameter int ACC_W     = 24,
  parameter int NUM_STAGE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [A_W-1:0] din0,
  input  logic [B_W-1:0]       din1,
  input  logic                 in_first,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [P_W-1:0]       dout,
  output logic                 acc_valid,
  output logic [ACC_W-1:0]     acc_out,
  output logic                 acc_ovf
);

  localparam int c_PROD_W = full_prod_w(A_W, B_W, B_SIGNED);
  localparam int c_BX_W   = c_PROD_W - A_W;
  localparam int c_LAST   = NUM_STAGE - 1;

  logic                 w_stall;
  logic [c_BX_W-1:0]    w_b_ext;
  logic [c_PROD_W-1:0]  w_stage_d [NUM_STAGE];
  logic [c_PROD_W-1:0]  w_stage_q [NUM_STAGE];
  logic                 w_vld_d   [NUM_STAGE];
  logic                 w_vld_q   [NUM_STAGE];
  mac_flags_t           w_flg_d   [NUM_STAGE];
  mac_flags_t           w_flg_q   [NUM_STAGE];

  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall;

  generate
    if (B_SIGNED != 0) begin : g_b_signed
      assign w_b_ext = din1;
    end else begin : g_b_unsigned
      assign w_b_ext = {1'b0, din1};
    end
  endgenerate

  // Stage 0 carries {a, b_ext}, which is exactly one product width wide.
  logic signed [A_W-1:0]      w_op_a;
  logic signed [c_BX_W-1:0]   w_op_b;
  logic signed [c_PROD_W-1:0] w_op_a_ext;
  logic signed [c_PROD_W-1:0] w_op_b_ext;
  logic signed [c_PROD_W-1:0] w_prod;

  assign {w_op_a, w_op_b} = w_stage_q[0];
  assign w_op_a_ext = {{c_BX_W{w_op_a[A_W-1]}}, w_op_a};
  assign w_op_b_ext = {{A_W{w_op_b[c_BX_W-1]}}, w_op_b};
  assign w_prod     = w_op_a_ext * w_op_b_ext;

  generate
    for (genvar i = 0; i < NUM_STAGE; i++) begin : g_stage
      if (i == 0) begin : g_in
        assign w_vld_d[i]   = in_valid & in_ready;
        assign w_stage_d[i] = {din0, w_b_ext};
        assign w_flg_d[i]   = {in_first, in_last};
      end else begin : g_chain
        assign w_vld_d[i] = w_vld_q[i-1];
        assign w_flg_d[i] = w_flg_q[i-1];
        if (i == 1) begin : g_mul
          assign w_stage_d[i] = w_prod;
        end else begin : g_dly
          assign w_stage_d[i] = w_stage_q[i-1];
        end
      end

      clusterop_mac_stage #(
        .DATA_W (c_PROD_W)
      ) u_stage (
        .clk       (clk),
        .reset     (reset),
        .stall     (w_stall),
        .in_valid  (w_vld_d[i]),
        .in_data   (w_stage_d[i]),
        .in_flags  (w_flg_d[i]),
        .out_valid (w_vld_q[i]),
        .out_data  (w_stage_q[i]),
        .out_flags (w_flg_q[i])
      );
    end
  endgenerate

  logic [c_PROD_W-1:0]     w_out_prod;
  mac_flags_t              w_out_flg;
  logic signed [ACC_W-1:0] w_prod_acc;

  assign out_valid  = w_vld_q[c_LAST];
  assign w_out_prod = w_stage_q[c_LAST];
  assign w_out_flg  = w_flg_q[c_LAST];
  assign acc_valid  = out_valid & w_out_flg.last;

  generate
    if (P_W > c_PROD_W) begin : g_dout_sext
      assign dout = {{(P_W - c_PROD_W){w_out_prod[c_PROD_W-1]}}, w_out_prod};
    end else begin : g_dout_trunc
      assign dout = w_out_prod[P_W-1:0];
    end

    if (ACC_W > c_PROD_W) begin : g_pacc_sext
      assign w_prod_acc = {{(ACC_W - c_PROD_W){w_out_prod[c_PROD_W-1]}}, w_out_prod};
    end else begin : g_pacc_trunc
      assign w_prod_acc = w_out_prod[ACC_W-1:0];
    end
  endgenerate

  logic                    w_out_fire;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_base;
  logic signed [ACC_W-1:0] w_sum;

  assign w_out_fire = out_valid & out_ready;
  assign w_base     = w_out_flg.first ? '0 : r_acc;

`ifdef CLUSTEROP_MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] c_SAT_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic signed [ACC_W-1:0] c_SAT_MIN = ACC_W'(sat_min(ACC_W));

  logic [ACC_W:0] w_sum_wide;
  logic           w_ovf_now;
  logic           r_ovf;

  // One guard bit: overflow shows up as disagreement between the top two bits.
  assign w_sum_wide = {w_base[ACC_W-1], w_base} + {w_prod_acc[ACC_W-1], w_prod_acc};
  assign w_ovf_now  = w_sum_wide[ACC_W] ^ w_sum_wide[ACC_W-1];
  assign w_sum      = !w_ovf_now ? w_sum_wide[ACC_W-1:0]
                    : (w_sum_wide[ACC_W] ? c_SAT_MIN : c_SAT_MAX);
  assign acc_ovf    = r_ovf | w_ovf_now;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (w_out_fire) begin
      r_ovf <= w_out_flg.last ? 1'b0 : acc_ovf;
    end
  end
`else
  assign w_sum   = w_base + w_prod_acc;
  assign acc_ovf = 1'b0;
`endif

  assign acc_out = w_sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (w_out_fire) begin
      r_acc <= w_out_flg.last ? '0 : w_sum;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_clusterop_mac_pipe.sv
// ============================================================================
// Module      : tb_clusterop_mac_pipe
// Description : Self-checking bench for clusterop_mac_pipe against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clusterop_mac_pipe;

`ifdef CLUSTEROP_MAC_SAT_EN
  localparam bit c_SAT = 1'b1;
`else
  localparam bit c_SAT = 1'b0;
`endif

  localparam longint c_ACC_MAX = 64'sd8388607;
  localparam longint c_ACC_MIN = -64'sd8388608;

  typedef struct {
    int a;
    int b;
    bit first;
    bit last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic              iv   [3];
  logic              ir   [3];
  logic signed [12:0] a_v [3];
  logic [8:0]        b_v  [3];
  logic              f_v  [3];
  logic              l_v  [3];
  logic              ov   [3];
  logic              ordy [3];
  logic [12:0]       dout_v [3];
  logic              accv [3];
  logic [23:0]       acc_v [3];
  logic              ovf  [3];

  always #5 clk = ~clk;

  clusterop_mac_pipe u_dut (
    .clk(clk), .reset(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .din0(a_v[0]), .din1(b_v[0]), .in_first(f_v[0]), .in_last(l_v[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .dout(dout_v[0]),
    .acc_valid(accv[0]), .acc_out(acc_v[0]), .acc_ovf(ovf[0])
  );

  clusterop_mac_pipe #(.NUM_STAGE(2), .B_SIGNED(1)) u_dut2 (
    .clk(clk), .reset(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .din0(a_v[1]), .din1(b_v[1]), .in_first(f_v[1]), .in_last(l_v[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .dout(dout_v[1]),
    .acc_valid(accv[1]), .acc_out(acc_v[1]), .acc_ovf(ovf[1])
  );

  clusterop_mac_pipe #(.NUM_STAGE(8), .B_SIGNED(1)) u_dut8 (
    .clk(clk), .reset(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .din0(a_v[2]), .din1(b_v[2]), .in_first(f_v[2]), .in_last(l_v[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .dout(dout_v[2]),
    .acc_valid(accv[2]), .acc_out(acc_v[2]), .acc_ovf(ovf[2])
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  beat_t  q[$];
  beat_t  stim[$];
  beat_t  cur_beat;
  longint ref_acc = 0;
  bit     ref_ovf = 1'b0;

  logic [12:0] hist_dout[$];
  logic [23:0] hist_acc[$];
  bit          hist_accv[$];
  bit          hist_ovf[$];
  int          hist_cyc[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected output of a beat given the current group state (plain arithmetic).
  function automatic void model_eval(input beat_t bt, output logic [12:0] e_dout,
                                     output logic [23:0] e_acc, output bit e_ovf);
    longint prod, sum;
    logic [63:0] pv, sv;
    bit now;
    prod   = longint'(bt.a) * longint'(bt.b);
    pv     = prod;
    e_dout = pv[12:0];
    sum    = (bt.first ? 64'sd0 : ref_acc) + prod;
    now    = 1'b0;
    if (c_SAT) begin
      if (sum > c_ACC_MAX) begin sum = c_ACC_MAX; now = 1'b1; end
      else if (sum < c_ACC_MIN) begin sum = c_ACC_MIN; now = 1'b1; end
    end
    sv    = sum;
    e_acc = sv[23:0];
    e_ovf = c_SAT ? (ref_ovf | now) : 1'b0;
  endfunction

  task automatic drive(input beat_t bt);
    cur_beat = bt;
    a_v[0] = 13'(bt.a);
    b_v[0] = 9'(bt.b);
    f_v[0] = bt.first;
    l_v[0] = bt.last;
  endtask

  task automatic step(output bit accepted);
    beat_t bt;
    logic [12:0] e_d;
    logic [23:0] e_a;
    bit e_o;
    #1;
    accepted = iv[0] && ir[0];
    if (ov[0] && ordy[0]) begin
      if (q.size() == 0) begin
        chk("spurious_out", ov[0], 0);
      end else begin
        bt = q.pop_front();
        model_eval(bt, e_d, e_a, e_o);
        chk("dout", dout_v[0], e_d);
        chk("acc_out", acc_v[0], e_a);
        chk("acc_valid", accv[0], bt.last);
        chk("acc_ovf", ovf[0], e_o);
        hist_dout.push_back(dout_v[0]);
        hist_acc.push_back(acc_v[0]);
        hist_accv.push_back(accv[0]);
        hist_ovf.push_back(ovf[0]);
        hist_cyc.push_back(cyc);
        if (bt.last) begin
          ref_acc = 0;
          ref_ovf = 1'b0;
        end else begin
          ref_acc = longint'($signed(e_a));
          ref_ovf = e_o;
        end
      end
    end else if (ov[0] && q.size() > 0) begin
      model_eval(q[0], e_d, e_a, e_o);
      chk("hold_dout", dout_v[0], e_d);
      chk("hold_acc", acc_v[0], e_a);
    end
    if (accepted) q.push_back(cur_beat);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_hist();
    hist_dout.delete(); hist_acc.delete(); hist_accv.delete();
    hist_ovf.delete(); hist_cyc.delete();
  endtask

  // Streams stim[] into DUT 0, holding out_ready low for cycles stall_lo..stall_hi.
  task automatic run_stream(input int stall_lo, input int stall_hi, input int max_cyc);
    int sent = 0;
    bit acc;
    clear_hist();
    for (int c = 0; c < max_cyc; c++) begin
      iv[0] = (sent < stim.size());
      if (sent < stim.size()) drive(stim[sent]);
      ordy[0] = !(c >= stall_lo && c <= stall_hi);
      if (!ordy[0]) begin
        #1;
        chk("stall_in_ready", ir[0], 0);
        chk("stall_out_valid", ov[0], 1);
      end
      step(acc);
      if (acc) sent++;
      if (sent == stim.size() && q.size() == 0) break;
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    chk("stream_drain", q.size() + (stim.size() - sent), 0);
  endtask

  task automatic lat_test(input int k, input int a, input int b, input int exp_lat,
                          input logic [12:0] e_dout, input logic [23:0] e_acc);
    int n = 0;
    @(negedge clk);
    a_v[k] = 13'(a); b_v[k] = 9'(b); f_v[k] = 1'b1; l_v[k] = 1'b1;
    ordy[k] = 1'b1; iv[k] = 1'b1;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      iv[k] = 1'b0;
    end while (!ov[k] && n < 20);
    chk($sformatf("latency_%0d", k), n, exp_lat);
    chk($sformatf("lat_dout_%0d", k), dout_v[k], e_dout);
    chk($sformatf("lat_acc_%0d", k), acc_v[k], e_acc);
    chk($sformatf("lat_accv_%0d", k), accv[k], 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit acc;
    bit pending;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 0; a_v[k] = 0; b_v[k] = 0; f_v[k] = 0; l_v[k] = 0; ordy[k] = 1;
    end
    repeat (3) @(negedge clk);
    chk("rst_out_valid", ov[0], 0);
    chk("rst_acc_valid", accv[0], 0);
    chk("rst_dout", dout_v[0], 0);
    chk("rst_acc_out", acc_v[0], 0);
    chk("rst_acc_ovf", ovf[0], 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single beat, latency and value
    lat_test(0, -5, 200, 4, 13'h1C18, 24'hFFFC18);

    // three-beat group back to back
    stim.delete();
    stim.push_back('{a: 100, b: 3,   first: 1'b1, last: 1'b0});
    stim.push_back('{a: -7,  b: 10,  first: 1'b0, last: 1'b0});
    stim.push_back('{a: 2,   b: 255, first: 1'b0, last: 1'b1});
    run_stream(-1, -1, 30);
    chk("grp_count", hist_dout.size(), 3);
    if (hist_dout.size() == 3) begin
      chk("grp_dout0", hist_dout[0], 13'd300);
      chk("grp_dout1", hist_dout[1], 13'h1FBA);
      chk("grp_dout2", hist_dout[2], 13'd510);
      chk("grp_acc2", hist_acc[2], 24'd740);
      chk("grp_accv", {hist_accv[0], hist_accv[1], hist_accv[2]}, 3'b001);
      chk("grp_consec", hist_cyc[2] - hist_cyc[0], 2);
    end

    // backpressure during a six-beat group
    stim.delete();
    for (int i = 0; i < 6; i++)
      stim.push_back('{a: int'($urandom_range(0, 8191)) - 4096, b: int'($urandom_range(0, 511)),
                       first: (i == 0), last: (i == 5)});
    run_stream(5, 7, 40);
    chk("bp_count", hist_dout.size(), 6);

    // saturation / wrap on a long group, then a fresh group
    stim.delete();
    for (int i = 0; i < 5; i++)
      stim.push_back('{a: -4096, b: 511, first: (i == 0), last: (i == 4)});
    run_stream(-1, -1, 30);
    chk("sat_count", hist_acc.size(), 5);
    if (hist_acc.size() == 5) begin
      chk("sat_acc", hist_acc[4], c_SAT ? 24'h800000 : 24'd6311936);
      chk("sat_ovf", hist_ovf[4], c_SAT);
    end
    stim.delete();
    stim.push_back('{a: 1, b: 1, first: 1'b1, last: 1'b1});
    run_stream(-1, -1, 20);
    if (hist_ovf.size() == 1) chk("next_grp_ovf", hist_ovf[0], 0);
    else chk("next_grp_count", hist_ovf.size(), 1);

    // asynchronous reset with beats in flight
    ordy[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[0] = 1'b1;
      drive('{a: i + 1, b: 5, first: (i == 0), last: 1'b0});
      step(acc);
    end
    iv[0] = 1'b0;
    step(acc);
    chk("pre_rst_out_valid", ov[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", ov[0], 0);
    chk("async_rst_dout", dout_v[0], 0);
    chk("async_rst_acc", acc_v[0], 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    ref_acc = 0;
    ref_ovf = 1'b0;
    ordy[0] = 1'b1;
    for (int i = 0; i < 10; i++) step(acc);
    stim.delete();
    stim.push_back('{a: 3, b: 4, first: 1'b1, last: 1'b1});
    run_stream(-1, -1, 20);
    if (hist_acc.size() == 1) chk("post_rst_acc", hist_acc[0], 24'd12);
    else chk("post_rst_count", hist_acc.size(), 1);

    // parameter sweep: signed b, shallow and deep pipes
    lat_test(1, 7, 9'h1FF, 2, 13'h1FF9, 24'hFFFFF9);
    lat_test(2, 7, 9'h1FF, 8, 13'h1FF9, 24'hFFFFF9);

    // randomized traffic with random backpressure
    pending = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!pending && $urandom_range(0, 3) != 0) begin
        drive('{a: int'($urandom_range(0, 8191)) - 4096, b: int'($urandom_range(0, 511)),
                first: ($urandom_range(0, 3) == 0), last: ($urandom_range(0, 3) == 0)});
        pending = 1'b1;
      end
      iv[0] = pending;
      ordy[0] = ($urandom_range(0, 3) != 0);
      step(acc);
      if (acc) pending = 1'b0;
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    for (int c = 0; c < 30 && q.size() > 0; c++) step(acc);
    chk("rand_drain", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
